// File: rtl/wb_stage_arb_pkg.sv
// wb_stage_arb_pkg: shared constants for the write-back stage
package wb_stage_arb_pkg;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam int LINK_REG_DEFAULT = 31;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/wb_stage_arb_if.sv
// wb_stage_arb_if: MEM-side inputs and register-file/forwarding outputs of the write-back stage
interface wb_stage_arb_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int LL_DEPTH = 2
);
  localparam int CW = $clog2(LL_DEPTH + 1);
  logic i_flush, i_valid, i_mem_unsigned, i_reg_write, i_mem_to_reg, i_is_jal, i_ll_valid;
  logic [DATA_W-1:0] i_alu_result, i_read_data, i_pc_plus_4, i_ll_data;
  logic [1:0] i_addr_lo, i_mem_size;
  logic [REG_AW-1:0] i_write_register, i_ll_reg;
  logic o_ll_ready, o_stall_req, o_reg_write, o_misalign;
  logic [DATA_W-1:0] o_write_data;
  logic [REG_AW-1:0] o_write_register;
  logic [CW-1:0] o_ll_count;
  modport master (
    output i_flush, i_valid, i_alu_result, i_read_data, i_addr_lo, i_mem_size, i_mem_unsigned,
           i_write_register, i_reg_write, i_mem_to_reg, i_pc_plus_4, i_is_jal, i_ll_valid, i_ll_reg, i_ll_data,
    input  o_ll_ready, o_stall_req, o_write_data, o_write_register, o_reg_write, o_misalign, o_ll_count
  );
  modport slave (
    input  i_flush, i_valid, i_alu_result, i_read_data, i_addr_lo, i_mem_size, i_mem_unsigned,
           i_write_register, i_reg_write, i_mem_to_reg, i_pc_plus_4, i_is_jal, i_ll_valid, i_ll_reg, i_ll_data,
    output o_ll_ready, o_stall_req, o_write_data, o_write_register, o_reg_write, o_misalign, o_ll_count
  );
endinterface

// File: rtl/wb_stage_arb_ll_fifo.sv
// wb_ll_fifo: compacting long-latency result queue with pop-head and kill-by-register
module wb_ll_fifo #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [REG_AW-1:0] push_reg_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [REG_AW-1:0] kill_reg_i,
  output logic              head_valid_o,
  output logic [REG_AW-1:0] head_reg_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CW-1:0]     count_o
);
  logic [DEPTH-1:0] v_q, v_d;
  logic [REG_AW-1:0] r_q [DEPTH];
  logic [REG_AW-1:0] r_d [DEPTH];
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [CW-1:0] n_q, n_d;
  int j;
  // Survivors shift toward slot 0 so the head is always slot 0 and killed holes vanish
  always_comb begin
    v_d = '0;
    r_d = r_q;
    d_d = d_q;
    j = 0;
    for (int i = 0; i < DEPTH; i++)
      if (v_q[i] && !(kill_i && r_q[i] == kill_reg_i) && !(pop_i && i == 0)) begin
        v_d[j] = 1'b1;
        r_d[j] = r_q[i];
        d_d[j] = d_q[i];
        j++;
      end
    if (push_i) begin
      v_d[j] = 1'b1;
      r_d[j] = push_reg_i;
      d_d[j] = push_data_i;
      j++;
    end
    n_d = CW'(j);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v_q <= '0;
      r_q <= '{default: '0};
      d_q <= '{default: '0};
      n_q <= '0;
    end else begin
      v_q <= v_d;
      r_q <= r_d;
      d_q <= d_d;
      n_q <= n_d;
    end
  assign head_valid_o = v_q[0];
  assign head_reg_o = r_q[0];
  assign head_data_o = d_q[0];
  assign count_o = n_q;
endmodule

// File: rtl/wb_stage_arb.sv
// wb_stage_arb: MEM/WB register, load alignment, link writes and long-latency write-port sharing
module wb_stage_arb
  import wb_stage_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  parameter int LL_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  wb_stage_arb_if.slave bus
);
  localparam int CW = $clog2(LL_DEPTH + 1);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] pc4;
    logic [1:0]        lo;
    logic [1:0]        sz;
    logic              uns;
    logic [REG_AW-1:0] wreg;
    logic              rw;
    logic              m2r;
    logic              jal;
  } stage_t;
  stage_t s_q, s_d;
  logic misalign, pw, push, head_v;
  logic [REG_AW-1:0] dest, head_reg;
  logic [DATA_W-1:0] load, wdata, head_data;
  logic [CW-1:0] count;
  function automatic logic [31:0] align(input logic [31:0] w, input logic [1:0] lo, input logic [1:0] sz, input logic u);
    logic [7:0] b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = w[16*lo[1] +: 16];
    return sz == MEM_SIZE_BYTE ? {{24{b[7] & ~u}}, b} : sz == MEM_SIZE_HALF ? {{16{h[15] & ~u}}, h} : w;
  endfunction
  always_comb begin
    s_d = '{valid: bus.i_valid & ~bus.i_flush & ~bus.o_stall_req, alu: bus.i_alu_result,
            rdata: bus.i_read_data, pc4: bus.i_pc_plus_4, lo: bus.i_addr_lo, sz: bus.i_mem_size,
            uns: bus.i_mem_unsigned, wreg: bus.i_write_register, rw: bus.i_reg_write,
            m2r: bus.i_mem_to_reg, jal: bus.i_is_jal};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) s_q <= '0;
    else s_q <= s_d;
  assign misalign = s_q.valid & s_q.m2r & ((s_q.sz == MEM_SIZE_HALF & s_q.lo[0]) | (s_q.sz == MEM_SIZE_WORD & s_q.lo != 2'b00));
  assign dest = s_q.jal ? REG_AW'(LINK_REG) : s_q.wreg;
  assign load = align(s_q.rdata, s_q.lo, s_q.sz, s_q.uns);
  assign wdata = s_q.jal ? s_q.pc4 : s_q.m2r ? load : s_q.alu;
  assign pw = s_q.valid & s_q.rw & ~misalign & (dest != REG_AW'(REG_ZERO));
  // Results aimed at r0 are acknowledged but never stored
  assign push = bus.i_ll_valid & bus.o_ll_ready & (bus.i_ll_reg != REG_AW'(REG_ZERO));
  wb_ll_fifo #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(LL_DEPTH), .CW(CW)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_reg_i   (bus.i_ll_reg),
    .push_data_i  (bus.i_ll_data),
    .pop_i        (~pw & head_v),
    .kill_i       (pw),
    .kill_reg_i   (dest),
    .head_valid_o (head_v),
    .head_reg_o   (head_reg),
    .head_data_o  (head_data),
    .count_o      (count)
  );
  assign bus.o_ll_count = count;
  assign bus.o_ll_ready = count < CW'(LL_DEPTH);
  assign bus.o_stall_req = count == CW'(LL_DEPTH);
  assign bus.o_misalign = misalign;
  assign bus.o_reg_write = pw | head_v;
  assign bus.o_write_register = pw ? dest : head_v ? head_reg : '0;
  assign bus.o_write_data = pw ? wdata : head_v ? head_data : '0;
endmodule

// File: tb/tb_wb_stage_arb.sv
// tb_wb_stage_arb: directed vectors checked against a queue-based model every cycle plus literal pins
module tb_wb_stage_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  wb_stage_arb_if #(.DATA_W(32), .REG_AW(5), .LL_DEPTH(2)) bus ();
  wb_stage_arb #(.DATA_W(32), .REG_AW(5), .LINK_REG(31), .LL_DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: what the MEM/WB slot holds, plus an ordered list of pending long-latency writes
  bit m_v, m_u, m_rw, m_m2r, m_jal;
  logic [31:0] m_alu, m_rd, m_pc4, sh, ld, val, ed;
  logic [1:0] m_lo, m_sz;
  logic [4:0] m_wr, dst, er;
  logic [36:0] mq[$];
  bit mis, pw, ew;
  int cnt;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_v = 0;
    end else begin
      sh = m_rd >> (m_sz == 2'b01 ? 16 * m_lo[1] : 8 * m_lo);
      case (m_sz)
        2'b00: begin ld = sh & 32'hFF; if (!m_u && ld[7]) ld = ld | 32'hFFFF_FF00; end
        2'b01: begin ld = sh & 32'hFFFF; if (!m_u && ld[15]) ld = ld | 32'hFFFF_0000; end
        default: ld = m_rd;
      endcase
      mis = m_v && m_m2r && ((m_sz == 2'b01 && m_lo[0]) || (m_sz == 2'b10 && m_lo != 0));
      dst = m_jal ? 5'd31 : m_wr;
      val = m_jal ? m_pc4 : m_m2r ? ld : m_alu;
      pw = m_v && m_rw && !mis && dst != 0;
      cnt = mq.size();
      if (pw) begin ew = 1; er = dst; ed = val; end
      else if (cnt > 0) begin ew = 1; er = mq[0][36:32]; ed = mq[0][31:0]; end
      else begin ew = 0; er = 0; ed = 0; end
      chk("reg_write", bus.o_reg_write, ew);
      chk("write_register", bus.o_write_register, er);
      chk("write_data", bus.o_write_data, ed);
      chk("misalign", bus.o_misalign, mis);
      chk("ll_count", bus.o_ll_count, cnt);
      chk("ll_ready", bus.o_ll_ready, cnt < 2);
      chk("stall_req", bus.o_stall_req, cnt == 2);
      if (pw) begin
        for (int i = cnt - 1; i >= 0; i--) if (mq[i][36:32] == dst) mq.delete(i);
      end else if (cnt > 0) mq.pop_front();
      if (bus.i_ll_valid && cnt < 2 && bus.i_ll_reg != 0) mq.push_back({bus.i_ll_reg, bus.i_ll_data});
      m_v = bus.i_valid && !bus.i_flush && cnt != 2;
      m_alu = bus.i_alu_result; m_rd = bus.i_read_data; m_pc4 = bus.i_pc_plus_4;
      m_lo = bus.i_addr_lo; m_sz = bus.i_mem_size; m_u = bus.i_mem_unsigned;
      m_rw = bus.i_reg_write; m_m2r = bus.i_mem_to_reg; m_jal = bus.i_is_jal; m_wr = bus.i_write_register;
    end
  end

  task automatic pipe(input bit v, input logic [31:0] alu, rd, pc4, input logic [1:0] lo, sz,
                      input bit u, m2r, jal, input logic [4:0] wr);
    bus.i_valid = v; bus.i_alu_result = alu; bus.i_read_data = rd; bus.i_pc_plus_4 = pc4;
    bus.i_addr_lo = lo; bus.i_mem_size = sz; bus.i_mem_unsigned = u; bus.i_reg_write = v;
    bus.i_mem_to_reg = m2r; bus.i_is_jal = jal; bus.i_write_register = wr; bus.i_flush = 0;
  endtask
  task automatic ld_op(input logic [31:0] rd, input logic [1:0] lo, sz, input bit u, input logic [4:0] wr);
    pipe(1, {30'h0, lo}, rd, 0, lo, sz, u, 1, 0, wr);
  endtask
  task automatic alu_op(input logic [4:0] wr, input logic [31:0] v);
    pipe(1, v, 0, 0, v[1:0], 2'b10, 0, 0, 0, wr);
  endtask
  task automatic bubble();
    pipe(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
  endtask
  task automatic ll(input bit v, input logic [4:0] r, input logic [31:0] d);
    bus.i_ll_valid = v; bus.i_ll_reg = r; bus.i_ll_data = d;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bubble();
    ll(0, 0, 0);
    repeat (2) tick();
    chk("rst_ready", bus.o_ll_ready, 1);
    chk("rst_reg_write", bus.o_reg_write, 0);
    chk("rst_count", bus.o_ll_count, 0);
    chk("rst_stall", bus.o_stall_req, 0);
    chk("rst_data", bus.o_write_data, 0);
    reset = 0;
    ld_op(32'h8001_7F80, 0, 2'b00, 0, 2); tick();
    chk("lb_signed", bus.o_write_data, 32'hFFFF_FF80);
    chk("lb_reg", bus.o_write_register, 2);
    ld_op(32'h8001_7F80, 0, 2'b00, 1, 2); tick();
    chk("lbu", bus.o_write_data, 32'h0000_0080);
    ld_op(32'h8001_7F80, 1, 2'b00, 0, 2); tick();
    chk("lb_off1", bus.o_write_data, 32'h0000_007F);
    ld_op(32'h8001_7F80, 2, 2'b01, 0, 2); tick();
    chk("lh_hi", bus.o_write_data, 32'hFFFF_8001);
    ld_op(32'h8001_7F80, 2, 2'b10, 0, 2); tick();
    chk("lw_misalign", bus.o_misalign, 1);
    chk("lw_mis_nowrite", bus.o_reg_write, 0);
    pipe(1, 0, 0, 32'h0040_0010, 0, 2'b10, 0, 0, 1, 5); tick();
    chk("jal_data", bus.o_write_data, 32'h0040_0010);
    chk("jal_reg", bus.o_write_register, 31);
    alu_op(0, 32'h1234); tick();
    chk("r0_nowrite", bus.o_reg_write, 0);
    alu_op(15, 32'h55); bus.i_flush = 1; tick();
    chk("flush_nowrite", bus.o_reg_write, 0);
    bubble(); ll(1, 0, 32'hDEAD); tick();
    chk("ll_r0_discard", bus.o_ll_count, 0);
    // collision: pending r8 waits behind three r9 pipeline writes
    alu_op(9, 1); ll(1, 8, 32'hAAAA); tick();
    chk("col_w1", bus.o_write_register, 9);
    chk("col_c1", bus.o_ll_count, 1);
    alu_op(9, 2); ll(0, 0, 0); tick();
    chk("col_c2", bus.o_ll_count, 1);
    alu_op(9, 3); tick();
    chk("col_c3", bus.o_ll_count, 1);
    bubble(); tick();
    chk("col_r8_reg", bus.o_write_register, 8);
    chk("col_r8_data", bus.o_write_data, 32'hAAAA);
    tick();
    chk("col_c0", bus.o_ll_count, 0);
    // full and stall
    alu_op(10, 32'hA0); ll(1, 3, 32'h33); tick();
    alu_op(11, 32'hB0); ll(1, 4, 32'h44); tick();
    chk("full_count", bus.o_ll_count, 2);
    chk("full_ready", bus.o_ll_ready, 0);
    chk("full_stall", bus.o_stall_req, 1);
    alu_op(12, 32'hC0); ll(0, 0, 0); tick();
    chk("drain_r3", bus.o_write_register, 3);
    chk("drain_r3_data", bus.o_write_data, 32'h33);
    tick();
    chk("drain_r4", bus.o_write_register, 4);
    chk("drain_stall_low", bus.o_stall_req, 0);
    tick();
    chk("drain_resume", bus.o_write_register, 12);
    // kill
    alu_op(7, 32'h77); ll(1, 6, 32'h1111); tick();
    alu_op(6, 32'h2222); ll(0, 0, 0); tick();
    chk("kill_data", bus.o_write_data, 32'h2222);
    bubble(); tick();
    chk("kill_count", bus.o_ll_count, 0);
    chk("kill_nowrite", bus.o_reg_write, 0);
    // asynchronous reset in the middle of a drain
    alu_op(13, 32'hD0); ll(1, 3, 32'h5); tick();
    alu_op(14, 32'hE0); ll(1, 4, 32'h6); tick();
    bubble(); ll(0, 0, 0); tick();
    chk("pre_rst_write", bus.o_reg_write, 1);
    #2 reset = 1;
    #1;
    chk("async_rst_count", bus.o_ll_count, 0);
    chk("async_rst_write", bus.o_reg_write, 0);
    tick();
    reset = 0;
    alu_op(20, 32'h2020); tick();
    chk("post_rst_write", bus.o_write_data, 32'h2020);
    bubble(); repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
